// File: rtl/hangman_host_display_if.sv
// Bundle between the host game logic and the Hangman LCD formatter: host
// inputs (word, guesses) and the formatted rows/status returned by the display.
interface hangman_host_display_if #(
    parameter int WORD_LEN  = 5,
    parameter int MAX_MISS  = 6,
    parameter int ROW_CHARS = 16
);
    localparam int MW = $clog2(MAX_MISS + 1);
    localparam int CW = $clog2(WORD_LEN + 1);

    logic                   new_game;
    logic [8*WORD_LEN-1:0]  word;
    logic                   guess_valid;
    logic [7:0]             letter;
    logic [WORD_LEN-1:0]    index_correct;
    logic [8*ROW_CHARS-1:0] top;
    logic [8*ROW_CHARS-1:0] bottom;
    logic [MW-1:0]          num_mistake;
    logic [CW-1:0]          num_correct;
    logic                   game_over;
    logic                   won;

    modport master (
        output new_game, word, guess_valid, letter, index_correct,
        input  top, bottom, num_mistake, num_correct, game_over, won
    );

    modport slave (
        input  new_game, word, guess_valid, letter, index_correct,
        output top, bottom, num_mistake, num_correct, game_over, won
    );
endinterface

// File: rtl/hangman_host_display.sv
// Host-side Hangman LCD formatter: tracks one game and renders two 16-char rows.
// Optional banner blink in WIN/LOSE is enabled by defining HOST_DISP_BLINK_EN.
module hangman_host_display #(
    parameter int WORD_LEN     = 5,
    parameter int MAX_MISS     = 6,
    parameter int ROW_CHARS    = 16,
    parameter int BLINK_CYCLES = 6000000
) (
    input  logic clk,
    input  logic nRst,
    hangman_host_display_if.slave bus
);
    localparam int MW       = $clog2(MAX_MISS + 1);
    localparam int CW       = $clog2(WORD_LEN + 1);
    localparam int WORD_OFF = (ROW_CHARS - WORD_LEN) / 2;
    localparam int HIST_OFF = (ROW_CHARS - MAX_MISS) / 2;
    localparam int WIN_OFF  = (ROW_CHARS - 3) / 2;
    localparam int LOSE_OFF = (ROW_CHARS - 4) / 2;
    localparam logic [23:0] WIN_TXT  = 24'h57_69_6E;        // "Win"
    localparam logic [31:0] LOSE_TXT = 32'h4C_6F_73_65;     // "Lose"
    localparam logic [8*ROW_CHARS-1:0] BLANK_ROW = {ROW_CHARS{8'h20}};

    if (WORD_LEN < 1 || WORD_LEN > ROW_CHARS || MAX_MISS < 1 || MAX_MISS > ROW_CHARS
        || BLINK_CYCLES < 1) begin : g_bad_params
        $error("hangman_host_display: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, WIN = 2'd2, LOSE = 2'd3} state_t;

    state_t                 state_r, state_next_s;
    logic [8*WORD_LEN-1:0]  word_r;
    logic [WORD_LEN-1:0]    revealed_r;     // same bit order as index_correct
    logic [CW-1:0]          correct_r;
    logic [MW-1:0]          mistake_r;
    logic [7:0]             hist_r [MAX_MISS];
    logic                   guess_s;
    logic                   hit_s;
    logic [WORD_LEN-1:0]    newly_s;
    logic [8*ROW_CHARS-1:0] top_s, bottom_s, top_r, bottom_r;
    logic                   banner_on_s;

    function automatic logic [CW-1:0] popcount(input logic [WORD_LEN-1:0] v);
        logic [CW-1:0] cnt;
        cnt = {CW{1'b0}};
        for (int i = 0; i < WORD_LEN; i++) begin
            cnt = cnt + CW'(v[i]);
        end
        return cnt;
    endfunction

    assign guess_s = bus.guess_valid && !bus.new_game && (state_r == PLAY);
    assign hit_s   = |bus.index_correct;
    assign newly_s = bus.index_correct & ~revealed_r;

    // State register
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a new game always wins over a same-cycle guess
    always_comb begin
        state_next_s = state_r;
        if (bus.new_game) begin
            state_next_s = PLAY;
        end else begin
            case (state_r)
                PLAY: begin
                    if (!guess_s) begin
                        state_next_s = PLAY;
                    end else if (hit_s) begin
                        state_next_s = (&(revealed_r | bus.index_correct)) ? WIN : PLAY;
                    end else begin
                        state_next_s = (mistake_r == MW'(MAX_MISS - 1)) ? LOSE : PLAY;
                    end
                end
                IDLE, WIN, LOSE: state_next_s = state_r;
                default:         state_next_s = IDLE;
            endcase
        end
    end

    // Game record: word, revealed mask, counters and wrong-guess history
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            word_r     <= {(8*WORD_LEN){1'b0}};
            revealed_r <= {WORD_LEN{1'b0}};
            correct_r  <= {CW{1'b0}};
            mistake_r  <= {MW{1'b0}};
            for (int j = 0; j < MAX_MISS; j++) hist_r[j] <= 8'h00;
        end else if (bus.new_game) begin
            word_r     <= bus.word;
            revealed_r <= {WORD_LEN{1'b0}};
            correct_r  <= {CW{1'b0}};
            mistake_r  <= {MW{1'b0}};
            for (int j = 0; j < MAX_MISS; j++) hist_r[j] <= 8'h00;
        end else if (guess_s && hit_s) begin
            revealed_r <= revealed_r | bus.index_correct;
            correct_r  <= correct_r + popcount(newly_s);
        end else if (guess_s && (mistake_r < MW'(MAX_MISS))) begin
            hist_r[mistake_r] <= bus.letter;
            mistake_r         <= mistake_r + 1'b1;
        end
    end

`ifdef HOST_DISP_BLINK_EN
    localparam int BW = $clog2(BLINK_CYCLES + 1);
    logic [BW-1:0] blink_cnt_r;
    logic          blink_off_r;

    // Blink timer: idles cleared, so every banner starts in its visible phase
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            blink_cnt_r <= {BW{1'b0}};
            blink_off_r <= 1'b0;
        end else if (bus.new_game || !((state_r == WIN) || (state_r == LOSE))) begin
            blink_cnt_r <= {BW{1'b0}};
            blink_off_r <= 1'b0;
        end else if (blink_cnt_r == BW'(BLINK_CYCLES - 1)) begin
            blink_cnt_r <= {BW{1'b0}};
            blink_off_r <= ~blink_off_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + 1'b1;
        end
    end

    assign banner_on_s = ~blink_off_r;
`else
    assign banner_on_s = 1'b1;
`endif

    // Row formatting from the settled game record
    always_comb begin
        top_s    = BLANK_ROW;
        bottom_s = BLANK_ROW;
        case (state_r)
            PLAY: begin
                for (int i = 0; i < WORD_LEN; i++) begin
                    if (revealed_r[WORD_LEN-1-i]) begin
                        top_s[8*(ROW_CHARS-WORD_OFF-i)-1 -: 8] = word_r[8*(WORD_LEN-i)-1 -: 8];
                    end else begin
                        top_s[8*(ROW_CHARS-WORD_OFF-i)-1 -: 8] = 8'h5F;
                    end
                end
                for (int j = 0; j < MAX_MISS; j++) begin
                    if (MW'(j) < mistake_r) begin
                        bottom_s[8*(ROW_CHARS-HIST_OFF-j)-1 -: 8] = hist_r[j];
                    end else begin
                        bottom_s[8*(ROW_CHARS-HIST_OFF-j)-1 -: 8] = 8'h5F;
                    end
                end
            end
            WIN, LOSE: begin
                if (!banner_on_s) begin
                    top_s = BLANK_ROW;
                end else if (state_r == WIN) begin
                    for (int k = 0; k < 3; k++) begin
                        top_s[8*(ROW_CHARS-WIN_OFF-k)-1 -: 8] = WIN_TXT[8*(3-k)-1 -: 8];
                    end
                end else begin
                    for (int k = 0; k < 4; k++) begin
                        top_s[8*(ROW_CHARS-LOSE_OFF-k)-1 -: 8] = LOSE_TXT[8*(4-k)-1 -: 8];
                    end
                end
                for (int i = 0; i < WORD_LEN; i++) begin
                    bottom_s[8*(ROW_CHARS-WORD_OFF-i)-1 -: 8] = word_r[8*(WORD_LEN-i)-1 -: 8];
                end
            end
            IDLE:    top_s = BLANK_ROW;
            default: top_s = BLANK_ROW;
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            top_r           <= BLANK_ROW;
            bottom_r        <= BLANK_ROW;
            bus.num_mistake <= {MW{1'b0}};
            bus.num_correct <= {CW{1'b0}};
            bus.game_over   <= 1'b0;
            bus.won         <= 1'b0;
        end else begin
            top_r           <= top_s;
            bottom_r        <= bottom_s;
            bus.num_mistake <= mistake_r;
            bus.num_correct <= correct_r;
            bus.game_over   <= (state_r == WIN) || (state_r == LOSE);
            bus.won         <= (state_r == WIN);
        end
    end

    assign bus.top    = top_r;
    assign bus.bottom = bottom_r;
endmodule
